// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encodings and the parity check.
// Shared with the receiver and the future transmitter.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } uart_state_e;

   // Data is zero-extended to 9 bits; the XOR is unaffected by the padding.
   function automatic logic parity_error(input logic [8:0] d, input logic p, input int mode);
      logic x;
      x = ^{d, p};
      case (mode)
         PAR_ODD:  return ~x;
         PAR_EVEN: return x;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level input; 2-cycle latency.
// The reset value is a parameter so idle-high lines come up idle.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: mid-bit sampling, configurable width/parity/stop bits.
// Character valid 1 cycle after the last stop sample; held until ready, later characters flagged as overrun.
module uart_rx_os import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF      = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL      = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic                 ferr_q, ferr_d;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 par_q;
   logic                 rxd_s;
   logic                 tick;
   logic                 shift_en, par_en, done, frame_bad;
   logic [8:0]           data9;
   logic                 perr;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rxd),
      .q     (rxd_s)
   );

   assign tick   = (cnt_q == '0);
   assign busy_o = (state_q != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = tick ? cnt_q : cnt_q - CW'(1);
      bit_d     = bit_q;
      stop_d    = stop_q;
      ferr_d    = ferr_q;
      shift_en  = 1'b0;
      par_en    = 1'b0;
      done      = 1'b0;
      frame_bad = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bit_d  = '0;
            stop_d = 1'b0;
            ferr_d = 1'b0;
            if (!rxd_s) begin
               cnt_d   = HALF;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               if (rxd_s) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = FULL;
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_en = 1'b1;
               cnt_d    = FULL;
               bit_d    = bit_q + BW'(1);
               if (bit_q == BIT_LAST)
                  state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (tick) begin
               par_en  = 1'b1;
               cnt_d   = FULL;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               cnt_d  = FULL;
               stop_d = ~stop_q;
               if (!rxd_s) ferr_d = 1'b1;
               // Decide on the final stop sample so a low first stop bit still yields one pulse.
               if (stop_q == STOP_LAST) begin
                  done      = 1'b1;
                  frame_bad = ferr_q | ~rxd_s;
                  state_d   = frame_bad ? ST_WAIT_IDLE : ST_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (rxd_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data9                = '0;
      data9[DATA_BITS-1:0] = shreg_q;
      perr                 = parity_error(data9, par_q, PARITY);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         bit_q        <= '0;
         stop_q       <= 1'b0;
         ferr_q       <= 1'b0;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         data_o       <= '0;
         valid_o      <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         stop_q      <= stop_d;
         ferr_q      <= ferr_d;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         if (shift_en) shreg_q <= {rxd_s, shreg_q[DATA_BITS-1:1]};
         if (par_en)   par_q   <= rxd_s;
         if (valid_o && ready_i) valid_o <= 1'b0;
         if (done) begin
            if (frame_bad) begin
               frame_err_o <= 1'b1;
            end else if (!valid_o || ready_i) begin
               data_o       <= shreg_q;
               parity_err_o <= perr;
               valid_o      <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8N1 instance and an 8E1 instance driven by directed frames.
module tb_uart_rx_os;

   typedef struct {
      logic [7:0] d;
      logic       pe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd_n = 1'b1, rxd_e = 1'b1;
   logic       ready_n = 1'b1, ready_e = 1'b1;
   logic [7:0] data_n, data_e;
   logic       valid_n, valid_e, perr_n, perr_e, ferr_n, ferr_e, ovr_n, ovr_e, busy_n, busy_e;

   exp_t q_n[$];
   exp_t q_e[$];
   int   n_cmp = 0, n_bad = 0;
   int   vcyc_n = 0, fcnt_n = 0, ocnt_n = 0, fcnt_e = 0, ocnt_e = 0;

   always #5 clk = ~clk;

   uart_rx_os #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
      .clk(clk), .rst_n(rst_n), .rxd(rxd_n), .data_o(data_n), .valid_o(valid_n),
      .ready_i(ready_n), .parity_err_o(perr_n), .frame_err_o(ferr_n),
      .overrun_o(ovr_n), .busy_o(busy_n));

   uart_rx_os #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
      .clk(clk), .rst_n(rst_n), .rxd(rxd_e), .data_o(data_e), .valid_o(valid_e),
      .ready_i(ready_e), .parity_err_o(perr_e), .frame_err_o(ferr_e),
      .overrun_o(ovr_e), .busy_o(busy_e));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitors: pop the scoreboard on every transfer and tally pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_n) vcyc_n++;
         if (ferr_n)  fcnt_n++;
         if (ovr_n)   ocnt_n++;
         if (valid_n && ready_n) begin
            if (q_n.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL n_unexpected: got data %0h, required no character", data_n);
            end else begin
               exp_t e;
               e = q_n.pop_front();
               check("n_data", 32'(data_n), 32'(e.d));
               check("n_perr", 32'(perr_n), 32'(e.pe));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (ferr_e) fcnt_e++;
         if (ovr_e)  ocnt_e++;
         if (valid_e && ready_e) begin
            if (q_e.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL e_unexpected: got data %0h, required no character", data_e);
            end else begin
               exp_t e;
               e = q_e.pop_front();
               check("e_data", 32'(data_e), 32'(e.d));
               check("e_perr", 32'(perr_e), 32'(e.pe));
            end
         end
      end
   end

   // One bit period (16 clocks) on the chosen line: 0 = 8N1 instance, 1 = 8E1 instance.
   task automatic drive(input int line, input logic v);
      @(posedge clk); #1;
      if (line == 0) rxd_n = v; else rxd_e = v;
      repeat (15) @(posedge clk);
   endtask

   task automatic send(input int line, input logic [7:0] d, input bit has_par,
                       input logic pbit, input logic stop);
      drive(line, 1'b0);
      for (int i = 0; i < 8; i++) drive(line, d[i]);
      if (has_par) drive(line, pbit);
      drive(line, stop);
      drive(line, 1'b1);
   endtask

   task automatic push_n(input logic [7:0] d, input logic pe);
      exp_t e;
      e.d = d; e.pe = pe;
      q_n.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},  32'(data_n),  32'h0);
      check({tag, "_valid"}, 32'(valid_n), 32'h0);
      check({tag, "_perr"},  32'(perr_n),  32'h0);
      check({tag, "_ferr"},  32'(ferr_n),  32'h0);
      check({tag, "_ovr"},   32'(ovr_n),   32'h0);
      check({tag, "_busy"},  32'(busy_n),  32'h0);
      check({tag, "_busy_e"},  32'(busy_e),  32'h0);
      check({tag, "_valid_e"}, 32'(valid_e), 32'h0);
   endtask

   int v0, f0, o0;

   initial begin
      // Reset state.
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);

      // 8N1 0xA5, ready high: one valid cycle, no errors.
      v0 = vcyc_n; f0 = fcnt_n; o0 = ocnt_n;
      push_n(8'hA5, 1'b0);
      send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      check("a5_valid_cycles", 32'(vcyc_n - v0), 32'd1);
      check("a5_ferr", 32'(fcnt_n - f0), 32'd0);
      check("a5_ovr",  32'(ocnt_n - o0), 32'd0);

      // 8E1 0x07 with wrong parity bit 0.
      begin
         exp_t e;
         e.d = 8'h07; e.pe = 1'b1;
         q_e.push_back(e);
      end
      send(1, 8'h07, 1'b1, 1'b0, 1'b1);
      check("e07_ferr", 32'(fcnt_e), 32'd0);

      // 8N1 0x3C with low stop bit, then a 40-bit break: one frame error, no character.
      v0 = vcyc_n; f0 = fcnt_n;
      drive(0, 1'b0);
      for (int i = 0; i < 8; i++) drive(0, (i == 2 || i == 3 || i == 4 || i == 5) ? 1'b1 : 1'b0);
      repeat (41) drive(0, 1'b0);
      drive(0, 1'b1);
      drive(0, 1'b1);
      check("brk_ferr_count", 32'(fcnt_n - f0), 32'd1);
      check("brk_no_valid",   32'(vcyc_n - v0), 32'd0);
      push_n(8'h55, 1'b0);
      send(0, 8'h55, 1'b0, 1'b0, 1'b1);
      check("after_brk_valid", 32'(vcyc_n - v0), 32'd1);

      // 4-cycle glitch: busy rises, START rejects it, no output.
      v0 = vcyc_n;
      @(posedge clk); #1 rxd_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 rxd_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("glitch_busy_hi", 32'(busy_n), 32'd1);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("glitch_busy_lo", 32'(busy_n), 32'd0);
      check("glitch_no_valid", 32'(vcyc_n - v0), 32'd0);

      // Overrun: 0x11 held, 0x22 dropped.
      o0 = ocnt_n;
      @(posedge clk); #1 ready_n = 1'b0;
      push_n(8'h11, 1'b0);
      send(0, 8'h11, 1'b0, 1'b0, 1'b1);
      send(0, 8'h22, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("ovr_count", 32'(ocnt_n - o0), 32'd1);
      check("ovr_hold_data", 32'(data_n), 32'h11);
      check("ovr_hold_valid", 32'(valid_n), 32'd1);
      @(posedge clk); #1 ready_n = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("ovr_valid_clr", 32'(valid_n), 32'd0);

      // Reset during bit 4 of 0xF0, then 0x81 received cleanly.
      fork
         send(0, 8'hF0, 1'b0, 1'b0, 1'b1);
         begin
            repeat (16 * 5 + 8) @(posedge clk);
            #1 rst_n = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check_reset_outputs("midrst");
            @(posedge clk); #1 rst_n = 1'b1;
         end
      join
      repeat (32) @(posedge clk);
      f0 = fcnt_n; o0 = ocnt_n;
      push_n(8'h81, 1'b0);
      send(0, 8'h81, 1'b0, 1'b0, 1'b1);
      check("x81_ferr", 32'(fcnt_n - f0), 32'd0);
      check("x81_ovr",  32'(ocnt_n - o0), 32'd0);

      // Drain with a bound; anything left unreceived is a failure.
      for (int i = 0; i < 2000 && (q_n.size() != 0 || q_e.size() != 0); i++) @(posedge clk);
      check("drain_n", 32'(q_n.size()), 32'd0);
      check("drain_e", 32'(q_e.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
